// File: rtl/tb_package.sv
// ============================================================================
// Module      : tb_package
// Description : Shared constants and FSM state types for the BLE command
//               assembler and its response transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tb_package;

  // Response bytes sent back to the host
  localparam logic [7:0]  COMM_COMPLETE     = 8'hA5;
  localparam logic [7:0]  COMM_INTERMEDIATE = 8'h5A;

  // Command codes
  localparam logic [15:0] CALIBRATE         = 16'h0000;

  // Rx assembly: waiting for the high byte or the low byte
  typedef enum logic [0:0] {
    RX_HIGH = 1'b0,
    RX_LOW  = 1'b1
  } rx_state_t;

  // Tx response: idle or waiting for the UART to finish
  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/resp_tx_ctrl.sv
// ============================================================================
// Module      : resp_tx_ctrl
// Description : Hands one response byte at a time to the UART transmitter.
//               Requests arriving while a byte is in flight are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module resp_tx_ctrl
  import tb_package::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] resp,
  input  logic       send_resp,
  input  logic       tx_done,
  output logic       trmt,
  output logic [7:0] tx_data,
  output logic       resp_sent
);

  tx_state_t  r_state;
  logic [7:0] r_tx_data;
  logic       r_trmt;
  logic       r_resp_sent;

  // Tx FSM: latch the byte and kick the UART, then wait for tx_done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= TX_IDLE;
      r_tx_data   <= 8'h00;
      r_trmt      <= 1'b0;
      r_resp_sent <= 1'b0;
    end else begin
      r_trmt      <= 1'b0;
      r_resp_sent <= 1'b0;
      if (r_state == TX_IDLE) begin
        // tx_done is meaningless here and is deliberately ignored
        if (send_resp) begin
          r_tx_data <= resp;
          r_trmt    <= 1'b1;
          r_state   <= TX_BUSY;
        end
      end else begin
        // tx_data stays frozen; new send_resp requests are dropped
        if (tx_done) begin
          r_resp_sent <= 1'b1;
          r_state     <= TX_IDLE;
        end
      end
    end
  end

  assign trmt      = r_trmt;
  assign tx_data   = r_tx_data;
  assign resp_sent = r_resp_sent;

endmodule

`default_nettype wire

// File: rtl/ble_cmd_assembler.sv
// ============================================================================
// Module      : ble_cmd_assembler
// Description : Assembles two UART bytes into a 16-bit command with an
//               inter-byte timeout and overrun flag, and forwards response
//               bytes to the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ble_cmd_assembler
  import tb_package::*;
#(
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frame_err,
  output logic        ovr,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done
);

  localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT_CLKS - 1);

  rx_state_t   r_rx_state;
  logic [7:0]  r_high;
  logic [15:0] r_cnt;
  logic [15:0] r_cmd;
  logic        r_cmd_rdy;
  logic        r_clr_rx_rdy;
  logic        r_frame_err;
  logic        r_ovr;

  logic        w_take;
  logic        w_complete;
  logic        w_timeout;

  // The receiver still shows rx_rdy during our acknowledge cycle; ignore it
  // there so a byte is never consumed twice.
  assign w_take     = rx_rdy & ~r_clr_rx_rdy;
  assign w_complete = w_take & (r_rx_state == RX_LOW);
  // A byte arriving on the timeout cycle wins over the timeout
  assign w_timeout  = (r_rx_state == RX_LOW) & ~w_take & (r_cnt == c_TO_LAST);

  // Rx FSM: high/low byte capture, acknowledge pulse and inter-byte timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state   <= RX_HIGH;
      r_high       <= 8'h00;
      r_cnt        <= 16'h0000;
      r_clr_rx_rdy <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_clr_rx_rdy <= w_take;
      r_frame_err  <= w_timeout;
      if (r_rx_state == RX_HIGH) begin
        if (w_take) begin
          r_high     <= rx_data;
          r_cnt      <= 16'h0000;
          r_rx_state <= RX_LOW;
        end
      end else begin
        if (w_take || w_timeout) begin
          r_rx_state <= RX_HIGH;
        end else begin
          r_cnt <= r_cnt + 16'h0001;
        end
      end
    end
  end

  // Command register: set on completion (set beats clear), flag overruns
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd     <= 16'h0000;
      r_cmd_rdy <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_ovr <= w_complete & r_cmd_rdy & ~clr_cmd_rdy;
      if (w_complete) begin
        r_cmd     <= {r_high, rx_data};
        r_cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end
    end
  end

  assign clr_rx_rdy = r_clr_rx_rdy;
  assign cmd        = r_cmd;
  assign cmd_rdy    = r_cmd_rdy;
  assign frame_err  = r_frame_err;
  assign ovr        = r_ovr;

  resp_tx_ctrl u_resp_tx_ctrl (
    .clk       (clk),
    .rst       (rst),
    .resp      (resp),
    .send_resp (send_resp),
    .tx_done   (tx_done),
    .trmt      (trmt),
    .tx_data   (tx_data),
    .resp_sent (resp_sent)
  );

endmodule

`default_nettype wire
